// File: rtl/data_mem_resp.sv
// data_mem_resp
//   Data-memory responder sitting behind the register file's memory port.
//   It services byte loads and stores against a 2**AW x 8 array. A request
//   is accepted with Req while Busy is low and is answered with a one-cycle
//   Ack exactly LATENCY edges after the accept edge.
//
// Handshake: Req is a valid qualifier sampled only on an edge where Busy==0
//   (IDLE or ACK state). Wen/Addr/WdatD are captured on that same edge.
//   While Busy==1 every input is ignored. Ack is a single-cycle pulse per
//   accepted request. Rdat is valid from the Ack of a load and is held
//   until the next load Ack.
//
// Parameters
//   AW       address width, array depth = 2**AW bytes
//   LATENCY  edges from accept to Ack, legal range 1..15
//
// Ports
//   Clk       clock, all state on posedge
//   Reset     asynchronous active-low reset
//   Req       request valid
//   Wen       1 = store, 0 = load
//   Addr      byte address
//   WdatD     store data
//   Busy      request in flight (WAIT state)
//   Ack       one-cycle completion pulse
//   Rdat      load data
//   DbgState  current FSM state, for observation only
//   LoadCnt   completed loads, saturating   (DMEM_STATS_EN only)
//   StoreCnt  completed stores, saturating  (DMEM_STATS_EN only)
//
// Build option: define DMEM_STATS_EN to add the LoadCnt/StoreCnt counters.

module data_mem_resp #(
  parameter int AW      = 8,
  parameter int LATENCY = 2
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Req,
  input  logic          Wen,
  input  logic [AW-1:0] Addr,
  input  logic [7:0]    WdatD,
  output logic          Busy,
  output logic          Ack,
  output logic [7:0]    Rdat,
  output logic [1:0]    DbgState
`ifdef DMEM_STATS_EN
  ,
  output logic [7:0]    LoadCnt,
  output logic [7:0]    StoreCnt
`endif
);

  generate
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("data_mem_resp: LATENCY must be in 1..15");
    end
  endgenerate

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [3:0]      cnt, cnt_nxt;
  logic            accept;
  logic            commit;

  // Latched request fields, used for commit once the request is in flight.
  logic            wen_q;
  logic [AW-1:0]   addr_q;
  logic [7:0]      wdat_q;

  // Cleared by reset and set on the first edge after release. Requests are
  // only accepted once armed, so an edge seen while Reset is low can never
  // commit a store even for LATENCY==1 (where commit coincides with accept).
  logic            armed;

  // Commit source: with LATENCY==1 the commit edge is the accept edge, so
  // the live inputs are used; otherwise the latched copies.
  logic            cmt_wen;
  logic [AW-1:0]   cmt_addr;
  logic [7:0]      cmt_wdat;

  logic [7:0]      mem [0:(1<<AW)-1];

  assign cmt_wen  = (LATENCY == 1) ? Wen   : wen_q;
  assign cmt_addr = (LATENCY == 1) ? Addr  : addr_q;
  assign cmt_wdat = (LATENCY == 1) ? WdatD : wdat_q;

  // Next-state logic
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    commit    = 1'b0;
    case (state)
      S_IDLE, S_ACK: begin
        if (armed && Req) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            state_nxt = S_ACK;
            commit    = 1'b1;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = LAT_M1;
          end
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        cnt_nxt = cnt - 4'd1;
        // cnt==1 means it reaches 0 on this edge: enter ACK and commit.
        if (cnt == 4'd1) begin
          state_nxt = S_ACK;
          commit    = 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State, request latch and load data
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state  <= S_IDLE;
      cnt    <= 4'd0;
      armed  <= 1'b0;
      wen_q  <= 1'b0;
      addr_q <= '0;
      wdat_q <= 8'h00;
      Rdat   <= 8'h00;
    end else begin
      armed <= 1'b1;
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        wen_q  <= Wen;
        addr_q <= Addr;
        wdat_q <= WdatD;
      end
      if (commit && !cmt_wen) begin
        Rdat <= mem[cmt_addr];
      end
    end
  end

  // Array is intentionally not reset; contents survive Reset.
  always_ff @(posedge Clk) begin
    if (commit && cmt_wen) begin
      mem[cmt_addr] <= cmt_wdat;
    end
  end

  assign Busy     = (state == S_WAIT);
  assign Ack      = (state == S_ACK);
  assign DbgState = state;

`ifdef DMEM_STATS_EN
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      LoadCnt  <= 8'h00;
      StoreCnt <= 8'h00;
    end else if (commit) begin
      if (!cmt_wen && LoadCnt != 8'hFF) begin
        LoadCnt <= LoadCnt + 8'd1;
      end
      if (cmt_wen && StoreCnt != 8'hFF) begin
        StoreCnt <= StoreCnt + 8'd1;
      end
    end
  end
`endif

  // An accepted request must carry a defined load/store select.
  a_wen_known: assert property (@(posedge Clk) disable iff (!Reset)
    (Req && !Busy) |-> !$isunknown(Wen));

endmodule

// File: tb/tb_data_mem_resp.sv
// tb_data_mem_resp
//   Two instances of data_mem_resp share one clock: index 0 with LATENCY=2
//   and index 1 with LATENCY=1. A byte-array reference model tracks memory
//   contents, the expected load data and the completion counts.
//   Inputs are driven on negedge, outputs sampled on negedge.

module tb_data_mem_resp;

  typedef struct packed {
    logic       w;
    logic [7:0] a;
    logic [7:0] d;
  } op_t;

  // Clock
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT signals, one slot per instance
  logic       rst_n [2];
  logic       req   [2];
  logic       wen   [2];
  logic [7:0] addr  [2];
  logic [7:0] wdat  [2];
  logic       busy  [2];
  logic       ack   [2];
  logic [7:0] rdat  [2];
  logic [1:0] dbg   [2];
`ifdef DMEM_STATS_EN
  logic [7:0] ldc   [2];
  logic [7:0] stc   [2];
`endif

  data_mem_resp #(.AW(8), .LATENCY(2)) u_lat2 (
    .Clk(clk), .Reset(rst_n[0]), .Req(req[0]), .Wen(wen[0]), .Addr(addr[0]),
    .WdatD(wdat[0]), .Busy(busy[0]), .Ack(ack[0]), .Rdat(rdat[0]),
    .DbgState(dbg[0])
`ifdef DMEM_STATS_EN
    , .LoadCnt(ldc[0]), .StoreCnt(stc[0])
`endif
  );

  data_mem_resp #(.AW(8), .LATENCY(1)) u_lat1 (
    .Clk(clk), .Reset(rst_n[1]), .Req(req[1]), .Wen(wen[1]), .Addr(addr[1]),
    .WdatD(wdat[1]), .Busy(busy[1]), .Ack(ack[1]), .Rdat(rdat[1]),
    .DbgState(dbg[1])
`ifdef DMEM_STATS_EN
    , .LoadCnt(ldc[1]), .StoreCnt(stc[1])
`endif
  );

  // Reference model
  logic [7:0] mem_m [2][256];
  logic [7:0] exp_rdat [2];
  int         ld_m [2];
  int         st_m [2];
  op_t        op_q [$];

  int n_checks = 0;
  int n_fails  = 0;

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive_op(input int i, input op_t op);
    req[i]  = 1'b1;
    wen[i]  = op.w;
    addr[i] = op.a;
    wdat[i] = op.d;
  endtask

  // Garbage on every input while the request is in flight; must be ignored.
  task automatic scramble(input int i);
    req[i]  = 1'($urandom_range(0, 1));
    wen[i]  = 1'($urandom_range(0, 1));
    addr[i] = 8'($urandom);
    wdat[i] = 8'($urandom);
  endtask

  task automatic model_complete(input int i, input op_t op);
    if (op.w) begin
      mem_m[i][op.a] = op.d;
      if (st_m[i] < 255) st_m[i]++;
    end else begin
      exp_rdat[i] = mem_m[i][op.a];
      if (ld_m[i] < 255) ld_m[i]++;
    end
  endtask

  task automatic check_stats(input int i);
`ifdef DMEM_STATS_EN
    check_val("load_cnt", ldc[i], ld_m[i]);
    check_val("store_cnt", stc[i], st_m[i]);
`endif
  endtask

  // Issues everything in op_q; Req stays high across each Ack while more
  // ops remain, so a queue of several ops exercises back-to-back accept.
  task automatic run_ops(input int i);
    op_t cur;
    int  k;
    @(negedge clk);
    if (op_q.size() == 0) return;
    cur = op_q.pop_front();
    drive_op(i, cur);
    forever begin
      @(negedge clk);
      k = 1;
      while (ack[i] !== 1'b1 && k < 20) begin
        check_val("busy_wait", busy[i], 1);
        scramble(i);
        @(negedge clk);
        k++;
      end
      if (ack[i] !== 1'b1) begin
        check_val("ack_timeout", ack[i], 1);
        req[i] = 1'b0;
        return;
      end
      check_val("ack_latency", k, lat_of(i));
      check_val("busy_at_ack", busy[i], 0);
      model_complete(i, cur);
      check_val("rdat", rdat[i], exp_rdat[i]);
      check_stats(i);
      if (op_q.size() > 0) begin
        cur = op_q.pop_front();
        drive_op(i, cur);
      end else begin
        req[i] = 1'b0;
        break;
      end
    end
    @(negedge clk);
    check_val("no_dup_ack", ack[i], 0);
    check_val("idle_busy", busy[i], 0);
  endtask

  // Asserts reset asynchronously mid-cycle and checks the immediate effect.
  task automatic pulse_reset(input int i);
    rst_n[i] = 1'b0;
    #1;
    check_val("rst_busy", busy[i], 0);
    check_val("rst_ack", ack[i], 0);
    check_val("rst_rdat", rdat[i], 8'h00);
    exp_rdat[i] = 8'h00;
    ld_m[i] = 0;
    st_m[i] = 0;
    check_stats(i);
    @(negedge clk);
    rst_n[i] = 1'b1;
  endtask

  // Accept one op, then reset while it is still in WAIT.
  task automatic start_then_reset(input int i, input op_t op);
    @(negedge clk);
    drive_op(i, op);
    @(negedge clk);
    check_val("abort_busy", busy[i], 1);
    req[i] = 1'b0;
    pulse_reset(i);
    @(negedge clk);
    check_val("abort_no_ack", ack[i], 0);
    @(negedge clk);
    check_val("abort_no_ack2", ack[i], 0);
  endtask

  op_t        op;
  logic [7:0] d21;
  int         st_before;

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0;
      req[i]   = 1'b0;
      wen[i]   = 1'b0;
      addr[i]  = 8'h00;
      wdat[i]  = 8'h00;
      exp_rdat[i] = 8'h00;
      ld_m[i] = 0;
      st_m[i] = 0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check_val("reset_busy", busy[i], 0);
      check_val("reset_ack", ack[i], 0);
      check_val("reset_rdat", rdat[i], 8'h00);
      check_stats(i);
    end
    check_val("reset_state_match", dbg[0], dbg[1]);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;

    // Fill every byte with a known value (long back-to-back store stream)
    for (int i = 0; i < 2; i++) begin
      for (int a = 0; a < 256; a++) begin
        op.w = 1'b1; op.a = 8'(a); op.d = 8'($urandom);
        op_q.push_back(op);
      end
      run_ops(i);
    end

    // Store A5 to 10 then load it back
    for (int i = 0; i < 2; i++) begin
      op.w = 1'b1; op.a = 8'h10; op.d = 8'hA5;
      op_q.push_back(op);
      run_ops(i);
      op.w = 1'b0; op.a = 8'h10; op.d = 8'h00;
      op_q.push_back(op);
      run_ops(i);
      check_val("load_a5", rdat[i], 8'hA5);
    end

    // Back-to-back: store 20, store 21, load 21
    for (int i = 0; i < 2; i++) begin
      d21 = 8'($urandom);
      op.w = 1'b1; op.a = 8'h20; op.d = 8'($urandom); op_q.push_back(op);
      op.w = 1'b1; op.a = 8'h21; op.d = d21;          op_q.push_back(op);
      op.w = 1'b0; op.a = 8'h21; op.d = 8'h00;        op_q.push_back(op);
      run_ops(i);
      check_val("b2b_rdat", rdat[i], d21);
    end

    // Reset during WAIT of a store: store dropped, prior content kept
    op.w = 1'b1; op.a = 8'h30; op.d = 8'h77;
    op_q.push_back(op);
    run_ops(0);
    op.w = 1'b1; op.a = 8'h30; op.d = 8'h3C;
    start_then_reset(0, op);
    op.w = 1'b0; op.a = 8'h30; op.d = 8'h00;
    op_q.push_back(op);
    run_ops(0);
    check_val("abort_keeps_old", rdat[0], 8'h77);

    // Randomized mix in bursts of 1..4 ops
    for (int i = 0; i < 2; i++) begin
      repeat (60) begin
        repeat ($urandom_range(1, 4)) begin
          op.w = 1'($urandom_range(0, 1));
          op.a = 8'($urandom);
          op.d = 8'($urandom);
          op_q.push_back(op);
        end
        run_ops(i);
      end
    end

    // 300 loads on the LATENCY=1 instance: load counter saturates
    st_before = st_m[1];
    repeat (75) begin
      repeat (4) begin
        op.w = 1'b0; op.a = 8'($urandom); op.d = 8'h00;
        op_q.push_back(op);
      end
      run_ops(1);
    end
`ifdef DMEM_STATS_EN
    check_val("load_cnt_sat", ldc[1], 8'hFF);
    check_val("store_cnt_hold", stc[1], st_before);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
